// File: rtl/rx_user_stream_checker.sv
// Checker for the received TCP payload stream: verifies the incrementing-byte
// pattern, counts accepted bytes and reports bytes per fixed cycle window.
module rx_user_stream_checker #(
  parameter int unsigned WINDOW_CYCLES = 156250000,
  parameter bit          CHECK_EN      = 1'b1
) (
  input  logic        s_aclk,
  input  logic        s_aresetn,
  input  logic        clear,
  input  logic        rx_user_tvalid,
  output logic        rx_user_tready,
  input  logic [63:0] rx_user_tdata,
  input  logic [7:0]  rx_user_tkeep,
  output logic [63:0] total_bytes,
  output logic [31:0] err_cnt,
  output logic [15:0] keep_err_cnt,
  output logic        pattern_lock,
  output logic [31:0] rate_bytes,
  output logic        rate_valid
);

  localparam int unsigned BYTES = 8;
  localparam int unsigned NW    = 4;
  localparam int unsigned WCW   = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic           ready_reg;
  logic [7:0]     exp_byte;
  logic [WCW-1:0] win_cnt;
  logic [31:0]    win_acc;

  logic           accept;
  logic           keep_legal;
  logic           beat_ok;
  logic           beat_bad;
  logic [NW-1:0]  beat_len;
  logic [NW-1:0]  ok_len;
  logic [7:0]     last_byte;
  logic           any_diff;
  logic           mismatch;
  logic           win_active;
  logic [32:0]    win_sum;
  logic [31:0]    win_sat;

  // Ready is withdrawn combinationally while clear is held so a colliding beat is refused.
  assign rx_user_tready = ready_reg & ~clear;
  assign accept         = rx_user_tvalid & rx_user_tready;

  // Beat decode: tkeep legality, length, last byte and pattern comparison.
  always_comb begin
    keep_legal = (rx_user_tkeep != 8'h00) &&
                 ((rx_user_tkeep & 8'(rx_user_tkeep + 8'd1)) == 8'h00);
    beat_len   = '0;
    last_byte  = '0;
    any_diff   = 1'b0;
    for (int k = 0; k < BYTES; k++) begin
      if (rx_user_tkeep[k]) beat_len = NW'(k + 1);
    end
    for (int k = 0; k < BYTES; k++) begin
      if (NW'(k) < beat_len) begin
        if (rx_user_tdata[8*k +: 8] != 8'(exp_byte + 8'(k))) any_diff = 1'b1;
      end
      if (NW'(k) == NW'(beat_len - NW'(1))) last_byte = rx_user_tdata[8*k +: 8];
    end
  end

  assign beat_ok    = accept & keep_legal;
  assign beat_bad   = accept & ~keep_legal;
  assign ok_len     = beat_ok ? beat_len : '0;
  // The seeding beat in IDLE is never reported as a mismatch.
  assign mismatch   = CHECK_EN && (state == RUN) && any_diff;
  assign win_active = (state == RUN) || beat_ok;
  assign win_sum    = {1'b0, win_acc} + 33'(ok_len);
  assign win_sat    = win_sum[32] ? 32'hFFFF_FFFF : win_sum[31:0];

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state        <= IDLE;
      ready_reg    <= 1'b0;
      exp_byte     <= '0;
      win_cnt      <= '0;
      win_acc      <= '0;
      total_bytes  <= '0;
      err_cnt      <= '0;
      keep_err_cnt <= '0;
      pattern_lock <= 1'b0;
      rate_bytes   <= '0;
      rate_valid   <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      ready_reg    <= 1'b1;
      exp_byte     <= '0;
      win_cnt      <= '0;
      win_acc      <= '0;
      total_bytes  <= '0;
      err_cnt      <= '0;
      keep_err_cnt <= '0;
      pattern_lock <= 1'b0;
      rate_bytes   <= '0;
      rate_valid   <= 1'b0;
    end else begin
      ready_reg  <= 1'b1;
      rate_valid <= 1'b0;

      if (beat_bad && keep_err_cnt != 16'hFFFF) keep_err_cnt <= keep_err_cnt + 16'd1;

      if (beat_ok) begin
        state       <= RUN;
        total_bytes <= total_bytes + 64'(beat_len);
        exp_byte    <= 8'(last_byte + 8'd1);
        if (mismatch) begin
          pattern_lock <= 1'b0;
          if (err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
        end else begin
          pattern_lock <= 1'b1;
        end
      end

      // Rate window: the closing cycle's beat still belongs to the window.
      if (win_active) begin
        if (win_cnt == WIN_LAST) begin
          rate_bytes <= win_sat;
          rate_valid <= 1'b1;
          win_acc    <= '0;
          win_cnt    <= '0;
        end else begin
          win_acc <= win_sat;
          win_cnt <= win_cnt + WCW'(1);
        end
      end
    end
  end

endmodule
